// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM state type and default constants for the SPI arbiter
package spi_pkg;

    localparam int SPI_WIDTH_DEFAULT   = 8;
    localparam int SPI_NREQ_DEFAULT    = 4;
    localparam int SPI_TIMEOUT_DEFAULT = 1023;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_arbiter_if.sv
// rtl/spi_arbiter_if.sv - requester and SPI-master side signals of the arbiter
interface spi_arbiter_if #(
    parameter int WIDTH = spi_pkg::SPI_WIDTH_DEFAULT,
    parameter int NREQ  = spi_pkg::SPI_NREQ_DEFAULT
);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  busy;
    logic                  spi_start;
    logic [WIDTH-1:0]      spi_tx_data;
    logic [WIDTH-1:0]      spi_rx_data;
    logic                  spi_rx_valid;

    // Arbiter side
    modport slave (
        input  req, req_data, spi_rx_data, spi_rx_valid,
        output gnt, rsp_valid, rsp_data, rsp_err, busy, spi_start, spi_tx_data
    );

    // Requesters plus SPI master side
    modport master (
        output req, req_data, spi_rx_data, spi_rx_valid,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy, spi_start, spi_tx_data
    );

endinterface

// File: rtl/spi_rr_pick.sv
// rtl/spi_rr_pick.sv - combinational round-robin picker starting the search at ptr
module spi_rr_pick
    import spi_pkg::*;
#(
    parameter int NREQ = SPI_NREQ_DEFAULT,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   winner
);

    // One extra bit so ptr + k (at most 2*NREQ-2) never overflows before the modulo
    localparam int SW = PW + 1;

    logic [SW-1:0] sum;
    logic [PW-1:0] idx;
    logic          found;

    // Scan requesters ptr, ptr+1, ... (mod NREQ) and grant the first one asserted
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter sharing one SPI master among NREQ requesters
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int WIDTH   = SPI_WIDTH_DEFAULT,
    parameter int NREQ    = SPI_NREQ_DEFAULT,
    parameter int TIMEOUT = SPI_TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_arbiter_if.slave bus
);

    localparam int            PW       = $clog2(NREQ);
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [PW-1:0] IDX_LAST = PW'(NREQ - 1);

    spi_state_e       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    winner_q, winner_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;
    logic             spi_start_q, spi_start_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;

    logic [NREQ-1:0]  pick_gnt;
    logic [PW-1:0]    pick_idx;

    spi_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .grant  (pick_gnt),
        .winner (pick_idx)
    );

    // Next-state and next-output logic; every output is taken from a flop
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        spi_start_d = 1'b0;
        tx_data_d   = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    gnt_d    = pick_gnt;
                    winner_d = pick_idx;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick_gnt[i]) begin
                            tx_data_d = bus.req_data[i*WIDTH +: WIDTH];
                        end
                    end
                    state_d = ST_START;
                end
            end
            ST_START: begin
                spi_start_d = 1'b1;
                cnt_d       = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // A frame completing on the terminal-count cycle still wins
                if (bus.spi_rx_valid) begin
                    rsp_data_d = bus.spi_rx_data;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_q >= CNT_LAST) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                rsp_valid_d = gnt_q;
                gnt_d       = '0;
                ptr_d       = (winner_q == IDX_LAST) ? '0 : winner_q + 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            winner_q    <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            spi_start_q <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            spi_start_q <= spi_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.busy        = busy_q;
    assign bus.spi_start   = spi_start_q;
    assign bus.spi_tx_data = tx_data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - self-checking bench for spi_arbiter with a transaction-level model
module tb_spi_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int TO = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks    = 0;
    int errors    = 0;
    int model_ptr = 0;
    int w;

    spi_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

    spi_arbiter #(
        .WIDTH   (W),
        .NREQ    (N),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first asserted request found scanning upward from p, wrapping
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One whole transaction. Called at a negedge with req already presented.
    // d < TO: spi_rx_valid is returned on WAIT cycle d+1; otherwise the SPI side stays silent.
    task automatic run_txn(input int d, input logic [W-1:0] rxd, input bit drop_mid,
                           input bit drop_after, output int win);
        logic [N-1:0] oh;
        logic [W-1:0] txw;
        int  n, starts, tx_bad, exp_n;
        bit  respond;
        win     = pick(bus.req, model_ptr);
        oh      = '0;
        oh[win] = 1'b1;
        txw     = bus.req_data[win*W +: W];
        respond = (d < TO);
        exp_n   = respond ? d + 2 : TO + 1;

        @(negedge clk);
        chk("gnt", bus.gnt, oh);
        chk("busy", bus.busy, 1);
        chk("start_early", bus.spi_start, 0);
        chk("rsp_single", bus.rsp_valid, 0);

        @(negedge clk);
        chk("spi_start", bus.spi_start, 1);
        chk("tx_data", bus.spi_tx_data, txw);

        n = 0; starts = 0; tx_bad = 0;
        while (n < TO + 8) begin
            if (respond && n == d) begin
                bus.spi_rx_valid = 1'b1;
                bus.spi_rx_data  = rxd;
            end
            @(negedge clk);
            n++;
            bus.spi_rx_valid = 1'b0;
            bus.spi_rx_data  = W'($urandom);
            starts += int'(bus.spi_start);
            if (drop_mid && n == 1) begin
                bus.req[win] = 1'b0;
                bus.req_data = ($urandom << 16) | $urandom;
            end
            if (bus.rsp_valid != '0) break;
            if (bus.spi_tx_data !== txw) tx_bad++;
        end

        chk("rsp_latency", n, exp_n);
        chk("start_once", starts, 0);
        chk("tx_stable", tx_bad, 0);
        chk("rsp_valid", bus.rsp_valid, oh);
        chk("rsp_data", bus.rsp_data, respond ? rxd : '0);
        chk("rsp_err", bus.rsp_err, !respond);
        chk("gnt_clear", bus.gnt, 0);

        model_ptr = (win + 1) % N;
        if (drop_after) bus.req[win] = 1'b0;
    endtask

    initial begin
        bus.req          = '0;
        bus.req_data     = '0;
        bus.spi_rx_data  = '0;
        bus.spi_rx_valid = 1'b0;

        // Outputs while held in reset
        repeat (2) @(negedge clk);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_spi_start", bus.spi_start, 0);
        chk("rst_tx_data", bus.spi_tx_data, 0);
        rst_n = 1'b1;

        // All four requesting continuously: strict rotation 0,1,2,3,0
        bus.req      = 4'b1111;
        bus.req_data = 32'h44332211;
        for (int t = 0; t < 5; t++) begin
            run_txn($urandom_range(0, 5), W'($urandom), 1'b0, 1'b0, w);
            chk("rotation_order", w, t % N);
        end
        bus.req = '0;

        // Single requester 2 with 0xA5, looped back by the SPI side
        bus.req                = 4'b0100;
        bus.req_data           = 32'h1234_5678;
        bus.req_data[2*W +: W] = 8'hA5;
        run_txn(3, 8'hA5, 1'b0, 1'b1, w);
        chk("single_winner", w, 2);

        // SPI side never answers: timeout response
        bus.req      = 4'b0001;
        bus.req_data = 32'hDEADBEEF;
        run_txn(TO + 5, 8'h00, 1'b0, 1'b1, w);

        // Answer arrives exactly on the terminal-count cycle
        bus.req      = 4'b0100;
        bus.req_data = 32'hCAFE_F00D;
        run_txn(TO - 1, 8'h3C, 1'b0, 1'b1, w);

        // Reset while waiting for the SPI frame
        bus.req = 4'b0010;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {bus.gnt, bus.rsp_valid, bus.rsp_err, bus.busy, bus.spi_start}, 0);
        chk("arst_rsp_data", bus.rsp_data, 0);
        chk("arst_tx_data", bus.spi_tx_data, 0);
        bus.req = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("arst_quiet", {bus.rsp_valid, bus.gnt, bus.busy}, 0);
        end
        model_ptr = 0;
        rst_n     = 1'b1;
        run_txn(2, 8'h5A, 1'b0, 1'b1, w);
        chk("first_after_reset", w, 0);

        // Requester 1 drops req (and data changes) mid-transaction; response still issued
        bus.req      = 4'b0010;
        bus.req_data = 32'h0000_9900;
        run_txn(4, 8'h77, 1'b1, 1'b1, w);
        chk("drop_mid_winner", w, 1);

        // Stray frame strobes while idle must not produce anything
        bus.req = '0;
        for (int c = 0; c < 4; c++) begin
            bus.spi_rx_valid = 1'b1;
            bus.spi_rx_data  = W'($urandom);
            @(negedge clk);
            bus.spi_rx_valid = 1'b0;
            chk("spurious_idle", {bus.gnt, bus.rsp_valid, bus.busy, bus.spi_start}, 0);
        end

        // Randomised request sets, payloads and SPI response delays
        for (int t = 0; t < 30; t++) begin
            bus.req      = N'($urandom_range(1, 15));
            bus.req_data = ($urandom << 16) ^ $urandom;
            run_txn($urandom_range(0, TO + 3), W'($urandom), 1'($urandom_range(0, 1)), 1'b1, w);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("final_idle", {bus.gnt, bus.busy, bus.rsp_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, SPI frame width in bits.
REQ-002 Parameter: NREQ, 4, number of requesters (2..8).
REQ-003 Parameter: TIMEOUT, 1023, max cycles waited for spi_rx_valid after spi_start.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester transfer request, level, held until own rsp_valid.
REQ-007 req_data  input  NREQ*WIDTH  per-requester TX word, slice i = bits [i*WIDTH +: WIDTH].
REQ-008 gnt  output  NREQ  one-hot grant, high for the whole owned transaction.
REQ-009 rsp_valid  output  NREQ  one-cycle response pulse to the owning requester.
REQ-010 rsp_data  output  WIDTH  received word, valid when any rsp_valid bit is high.
REQ-011 rsp_err  output  1  timeout flag, qualified by rsp_valid.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 spi_start  output  1  one-cycle start pulse to the SPI master.
REQ-014 spi_tx_data  output  WIDTH  word to send, stable from spi_start until return to IDLE.
REQ-015 spi_rx_data  input  WIDTH  received word from the SPI master.
REQ-016 spi_rx_valid  input  1  SPI master frame-complete strobe.

Function
REQ-017 FSM states: IDLE, START, WAIT, RESP; all outputs registered.
REQ-018 IDLE: if req != 0, pick winner round-robin beginning at index ptr, latch req_data slice into spi_tx_data, set gnt one-hot, go to START; else stay.
REQ-019 START: spi_start = 1 for exactly this cycle, clear timeout counter, go to WAIT.
REQ-020 WAIT: on spi_rx_valid capture spi_rx_data, rsp_err = 0, go to RESP; else increment counter and, on reaching TIMEOUT, set rsp_data = 0, rsp_err = 1, go to RESP.
REQ-021 RESP: rsp_valid[winner] = 1 for this cycle only, gnt cleared on exit, ptr = (winner+1) mod NREQ, go to IDLE.
REQ-022 Latency: req seen in IDLE at edge N -> gnt high at N+1, spi_start at N+2; spi_rx_valid sampled at edge M -> rsp_valid high after edge M+1.
REQ-023 Fairness: a continuously requesting set is served in strict rotation; no requester waits more than NREQ-1 transactions.
REQ-024 Simultaneous spi_rx_valid and timeout terminal count: spi_rx_valid wins, rsp_err = 0.
REQ-025 spi_rx_valid outside WAIT is ignored.
REQ-026 req dropped mid-transaction: transaction completes and rsp_valid still issued; req/req_data changes after IDLE have no effect.
REQ-027 At most one transaction outstanding; requests arriving while busy wait for the next IDLE.
REQ-028 Timeout counter width = clog2(TIMEOUT+1), saturating, never wraps.

Reset
REQ-029 rst_n low asynchronously forces state IDLE, ptr = 0, counter = 0, and gnt, rsp_valid, rsp_data, rsp_err, busy, spi_start, spi_tx_data all 0.
REQ-030 Reset mid-transaction aborts with no rsp_valid; first arbitration after reset gives priority to requester 0.

Structure
REQ-031 Shared package spi_pkg holds the FSM state type and the default WIDTH/TIMEOUT constants.
REQ-032 One sub-module spi_rr_pick: combinational round-robin picker, inputs req and ptr, outputs one-hot grant and winner index.
REQ-033 Block connects to spi_master through spi_start/spi_tx_data/spi_rx_data/spi_rx_valid only.

Verification
REQ-034 Single req[2], req_data slice = 0xA5, loopback MISO -> gnt = 0100, one spi_start, rsp_valid = 0100, rsp_data = 0xA5, rsp_err = 0.
REQ-035 req = 1111 held, four transactions -> service order 0,1,2,3, then 0 again.
REQ-036 Model never returns spi_rx_valid -> rsp_valid after exactly TIMEOUT WAIT cycles, rsp_err = 1, rsp_data = 0x00.
REQ-037 spi_rx_valid on the terminal-count cycle -> rsp_err = 0, captured data returned.
REQ-038 rst_n low in WAIT -> all outputs 0 immediately, no rsp_valid, next grant to requester 0.
REQ-039 req[1] dropped during WAIT, spurious spi_rx_valid in IDLE -> response still issued to requester 1; spurious strobe produces no output.
